axis_byte_packer: RTL



---
 rtl/axis_byte_packer_pkg.sv | 18 +
 rtl/axis_byte_packer_if.sv | 15 +
 rtl/axis_byte_packer_out_reg.sv | 43 ++++
 rtl/axis_byte_packer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/axis_byte_packer_pkg.sv
// Shared types and helpers for the AXI4-Stream byte packer.
// Frame modes, counter sizing and keep-mask generation.
package axis_byte_packer_pkg;

   typedef enum logic {
      MODE_PASS = 1'b0,
      MODE_PACK = 1'b1
   } frame_mode_e;

   function automatic int cntWidth(input int accBytes);
      return $clog2(accBytes + 1);
   endfunction

   function automatic logic [63:0] keepMask(input int n);
      return (64'd1 << n) - 64'd1;
   endfunction

endpackage

// File: rtl/axis_byte_packer_if.sv
// AXI4-Stream bundle with master (driver) and slave (receiver) views.
interface axis_byte_packer_if #(
   parameter int BYTES = 4
);

   logic [8*BYTES-1:0] tdata;
   logic [BYTES-1:0]   tkeep;
   logic               tvalid;
   logic               tlast;
   logic               tready;

   modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axis_byte_packer_out_reg.sv
// Single-entry registered AXI4-Stream output stage.
// o_free tells the producer a load this cycle will not overwrite an unsent beat.
module axis_out_reg #(
   parameter int BYTES = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_load,
   input  logic [8*BYTES-1:0]   i_data,
   input  logic [BYTES-1:0]     i_keep,
   input  logic                 i_last,
   output logic                 o_free,
   axis_byte_packer_if.master   m_axis
);

   logic [8*BYTES-1:0] r_data;
   logic [BYTES-1:0]   r_keep;
   logic               r_valid;
   logic               r_last;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_data  <= '0;
         r_keep  <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
      end else if (i_load) begin
         r_data  <= i_data;
         r_keep  <= i_keep;
         r_valid <= 1'b1;
         r_last  <= i_last;
      end else if (m_axis.tready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_free        = !r_valid || m_axis.tready;
   assign m_axis.tdata  = r_data;
   assign m_axis.tkeep  = r_keep;
   assign m_axis.tvalid = r_valid;
   assign m_axis.tlast  = r_last;

endmodule

// File: rtl/axis_byte_packer.sv
// Keeps the low KEEP_BYTES of each input beat and packs them densely into
// OUT_BYTES-wide output beats, or passes them through one beat per beat.
module axis_byte_packer
   import axis_byte_packer_pkg::*;
#(
   parameter int IN_BYTES   = 4,
   parameter int KEEP_BYTES = 3,
   parameter int OUT_BYTES  = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pack_en,
   axis_byte_packer_if.slave  in_AXIS,
   axis_byte_packer_if.master out_AXIS
);

   localparam int ACC  = OUT_BYTES + KEEP_BYTES - 1;
   localparam int ACCW = 8 * ACC;
   localparam int CW   = cntWidth(ACC);
   localparam logic [CW-1:0] OUT_CNT  = CW'(OUT_BYTES);
   localparam logic [CW-1:0] KEEP_CNT = CW'(KEEP_BYTES);

   generate
      if (KEEP_BYTES < 1 || KEEP_BYTES > IN_BYTES || KEEP_BYTES > OUT_BYTES) begin : g_badParams
         $error("axis_byte_packer: KEEP_BYTES must lie in 1..min(IN_BYTES, OUT_BYTES)");
      end
   endgenerate

   logic [ACCW-1:0]        r_acc;
   logic [CW-1:0]          r_cnt;
   logic                   r_lastPend;
   logic                   r_inFrame;
   frame_mode_e            r_mode;

   frame_mode_e            w_mode;
   logic                   w_free;
   logic                   w_loadA;
   logic                   w_loadB;
   logic                   w_drain;
   logic                   w_ready;
   logic                   w_accept;
   logic                   w_passLoad;
   logic                   w_load;
   logic [8*KEEP_BYTES-1:0] w_kept;
   logic [8*OUT_BYTES-1:0] w_ldData;
   logic [OUT_BYTES-1:0]   w_ldKeep;
   logic                   w_ldLast;
   logic [ACCW-1:0]        w_accNext;
   logic [CW-1:0]          w_cntNext;
   logic                   w_unused;

   assign w_unused = ^{in_AXIS.tkeep, in_AXIS.tdata};
   assign w_kept   = in_AXIS.tdata[8*KEEP_BYTES-1:0];

   // The mode is only taken from pack_en on a frame's first beat.
   assign w_mode     = r_inFrame ? r_mode : (pack_en ? MODE_PACK : MODE_PASS);
   assign w_loadA    = w_free && (r_cnt >= OUT_CNT);
   assign w_loadB    = w_free && r_lastPend && (r_cnt != '0) && (r_cnt < OUT_CNT);
   assign w_drain    = w_loadA || w_loadB;
   assign w_accept   = in_AXIS.tvalid && w_ready;
   assign w_passLoad = w_accept && (w_mode == MODE_PASS);
   assign w_load     = w_passLoad || w_drain;

   always_comb begin
      w_ready = 1'b0;
      if (!reset && !r_lastPend) begin
         if (!r_inFrame || r_mode == MODE_PASS) begin
            w_ready = w_free;
         end else begin
            w_ready = (r_cnt < OUT_CNT) || w_drain;
         end
      end
   end

   assign in_AXIS.tready = w_ready;

   always_comb begin
      w_ldData = '0;
      w_ldKeep = '0;
      w_ldLast = 1'b0;
      if (w_passLoad) begin
         w_ldData = (8*OUT_BYTES)'(w_kept);
         w_ldKeep = OUT_BYTES'(keepMask(KEEP_BYTES));
         w_ldLast = in_AXIS.tlast;
      end else if (w_loadA) begin
         w_ldData = r_acc[8*OUT_BYTES-1:0];
         w_ldKeep = '1;
         w_ldLast = r_lastPend && (r_cnt == OUT_CNT);
      end else if (w_loadB) begin
         w_ldKeep = OUT_BYTES'(keepMask(int'(r_cnt)));
         for (int b = 0; b < OUT_BYTES; b++) begin
            if (w_ldKeep[b]) w_ldData[8*b +: 8] = r_acc[8*b +: 8];
         end
         w_ldLast = 1'b1;
      end
   end

   // Bytes at and above cnt are always zero, so appending is a plain OR.
   always_comb begin
      w_accNext = r_acc;
      w_cntNext = r_cnt;
      if (w_loadA) begin
         w_accNext = r_acc >> (8*OUT_BYTES);
         w_cntNext = r_cnt - OUT_CNT;
      end else if (w_loadB) begin
         w_accNext = '0;
         w_cntNext = '0;
      end
      if (w_accept && w_mode == MODE_PACK) begin
         w_accNext = w_accNext | (ACCW'(w_kept) << (8*w_cntNext));
         w_cntNext = w_cntNext + KEEP_CNT;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc      <= '0;
         r_cnt      <= '0;
         r_lastPend <= 1'b0;
         r_inFrame  <= 1'b0;
         r_mode     <= MODE_PASS;
      end else begin
         r_acc <= w_accNext;
         r_cnt <= w_cntNext;
         if (w_accept) begin
            r_inFrame <= !in_AXIS.tlast;
            if (!r_inFrame) r_mode <= w_mode;
         end
         if (w_accept && in_AXIS.tlast && w_mode == MODE_PACK) begin
            r_lastPend <= 1'b1;
         end else if (w_load && w_ldLast) begin
            r_lastPend <= 1'b0;
         end
      end
   end

   axis_out_reg #(
      .BYTES (OUT_BYTES)
   ) u_outReg (
      .clk    (clk),
      .reset  (reset),
      .i_load (w_load),
      .i_data (w_ldData),
      .i_keep (w_ldKeep),
      .i_last (w_ldLast),
      .o_free (w_free),
      .m_axis (out_AXIS)
   );

endmodule
